car_traffic_controller: RTL
===========================

# car_traffic_controller

Upstream producer of the six car X positions consumed by the pixel colour/sprite stage. Once per video frame, at the start of vertical blanking, it advances every car by its lane speed plus the current level, wrapping at the screen edges. It then checks the player box against every car box and emits a one-cycle collision pulse with the lane index of the hit.

## Interface
- H_DISPLAY, 640: visible width; X wrap modulus.
- V_DISPLAY, 480: visible height; the frame-start line.
- CAR_WIDTH, 36 / CAR_HEIGHT, 32: car box size in pixels.
- PLAYER_WIDTH, 32 / PLAYER_HEIGHT, 32: player box size in pixels.
- CAR_Y1..CAR_Y6, 64/96/160/192/288/320: fixed top Y of each lane.
- SPEED1..SPEED6, 1/2/1/3/2/2: base pixels per frame for each lane, range 1..8.
- CLK  in  1  system/pixel clock; only clock.
- RST  in  1  synchronous, active-high reset.
- h_count, v_count  in  10  current raster position.
- player_x, player_y  in  10  player top-left corner.
- level  in  3  speed bonus added to every lane, 0..7.
- pause  in  1  when 1, frame starts are ignored.
- car_x1..car_x6  out  10  car top-left X, registered.
- collision  out  1  one-cycle pulse when any car overlaps the player.
- hit_lane  out  3  1..6, lowest-numbered overlapping lane; 0 when there is no hit.
- busy  out  1  high while in UPDATE or CHECK.

## Operation
- Reset values:
  - car_x1..car_x6 = 0, 100, 200, 300, 400, 500.
  - collision = 0, hit_lane = 0, busy = 0.
  - State = IDLE, index = 0.
- Frame start:
  - Condition: h_count == 0 and v_count == V_DISPLAY and pause == 0, sampled in IDLE.
  - The same condition in UPDATE or CHECK is ignored.
- State machine:
  - IDLE -> UPDATE on frame start, with index 0.
  - UPDATE: one car per cycle, index 0..5, then -> CHECK with index 0.
  - CHECK: one car per cycle, index 0..5, then -> IDLE.
- Speed rule:
  - s = SPEEDi + level.
  - Computed in 5 bits, maximum 15.
- Lanes 1, 3, 5 move left:
  - If x >= s: x <= x - s.
  - Otherwise: x <= x + H_DISPLAY - s.
- Lanes 2, 4, 6 move right:
  - If x + s < H_DISPLAY: x <= x + s.
  - Otherwise: x <= x + s - H_DISPLAY.
- X arithmetic uses 11 bits internally; every result lies in 0..H_DISPLAY-1.
- CHECK overlap test for car i is strict inequality on all four edges:
  - player_x < car_xi + CAR_WIDTH
  - car_xi < player_x + PLAYER_WIDTH
  - player_y < CAR_Yi + CAR_HEIGHT
  - CAR_Yi < player_y + PLAYER_HEIGHT
- Box extent is computed in 11 bits with no wrap. A car straddling the right edge collides only on its unwrapped part.
- Hit accumulation:
  - A hit flag and the first hit lane accumulate across CHECK.
  - Both are cleared on entry to CHECK.
- On leaving CHECK:
  - collision = hit flag.
  - hit_lane = first hit lane, or 0 with no hit.
- hit_lane holds its value until the next CHECK completes.
- The player inputs are sampled live during CHECK. The player stage must hold them stable during vblank.

## Timing
- Edge E0 samples the frame-start condition and sets busy = 1.
- car_x1..car_x6 update at edges E1..E6 respectively; each output changes exactly once per frame.
- CHECK evaluates car 1..6 using the registered car_x values at edges E7..E12.
- collision is high from E12 to E13; hit_lane is valid from E12.
- busy falls at E12. The block is back in IDLE at E12.
- Total latency is 12 cycles, all inside vblank. Outputs are stable throughout the visible area.
- RST during UPDATE or CHECK:
  - All outputs return to their reset values at the next edge.
  - No partial collision pulse is emitted.
- pause asserted mid-sequence does not abort the sequence. It only blocks new frame starts.
- A level change mid-UPDATE takes effect for the remaining cars of that frame.

## Test plan
- Reset: assert RST 2 cycles. Expect car_x = 0/100/200/300/400/500, collision = 0, hit_lane = 0, busy = 0.
- One frame, level = 0: drive the frame start. Expect car_x = 639/102/199/303/398/502, with car_x1 wrapping via 0 - 1. Expect car_xi to change at E(i), busy high for 12 cycles, and no collision with player at (600, 440).
- Wrap: preload car_x2 to 639 via frames, with level = 0 and SPEED2 = 2. Expect car_x2 = 1 after one frame. A left-mover at x = 3 with s = 5 must go to 638.
- Collision: player at (car_x1 + 10, CAR_Y1 + 5) at the time of CHECK. Expect collision high exactly 1 cycle at E12 to E13 and hit_lane = 1. Also test a player overlapping lanes 1 and 2 boxes, which gives hit_lane = 1. Then test touching edges only, player_x = car_x1 + 36, which gives no collision.
- Pause and level: with pause = 1 across a frame start, no car_x changes. With level = 7, lane 4 moves 10 pixels per frame.
- Reset mid-operation: assert RST at E3. Expect all outputs at reset values at the next edge, no collision pulse, and normal update on the following frame start.

Source files
------------

// File: rtl/car_traffic_controller.sv
// Per-frame car mover and player collision checker for six traffic lanes.
// At the vblank frame start, each car is stepped once. Each car box is then tested against the player box.

module car_lane #(
    parameter int H_DISPLAY     = 640,
    parameter int CAR_WIDTH     = 36,
    parameter int CAR_HEIGHT    = 32,
    parameter int PLAYER_WIDTH  = 32,
    parameter int PLAYER_HEIGHT = 32,
    parameter int CAR_Y         = 64,
    parameter int SPEED         = 1,
    parameter bit MOVE_LEFT     = 1'b1
) (
    input  logic [9:0] x,
    input  logic [2:0] level,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] x_next,
    output logic       overlap
);
    logic [4:0]  s;
    logic [10:0] x_w, s_w, h_w, sum, x_res;

    always_comb begin
        s     = 5'(SPEED) + 5'(level);
        x_w   = 11'(x);
        s_w   = 11'(s);
        h_w   = 11'(H_DISPLAY);
        sum   = x_w + s_w;
        x_res = x_w;
        if (MOVE_LEFT)
            x_res = (x_w >= s_w) ? (x_w - s_w) : (x_w + h_w - s_w);
        else
            x_res = (sum < h_w) ? sum : (sum - h_w);
        x_next = 10'(x_res);
    end

    // Extents are unwrapped, so a car straddling the right edge only hits on its left part.
    assign overlap = (11'(player_x) < 11'(x) + 11'(CAR_WIDTH))
                  && (11'(x) < 11'(player_x) + 11'(PLAYER_WIDTH))
                  && (11'(player_y) < 11'(CAR_Y + CAR_HEIGHT))
                  && (11'(CAR_Y) < 11'(player_y) + 11'(PLAYER_HEIGHT));
endmodule

module car_traffic_controller #(
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int CAR_WIDTH     = 36,
    parameter int CAR_HEIGHT    = 32,
    parameter int PLAYER_WIDTH  = 32,
    parameter int PLAYER_HEIGHT = 32,
    parameter int CAR_Y1 = 64,  parameter int CAR_Y2 = 96,  parameter int CAR_Y3 = 160,
    parameter int CAR_Y4 = 192, parameter int CAR_Y5 = 288, parameter int CAR_Y6 = 320,
    parameter int SPEED1 = 1, parameter int SPEED2 = 2, parameter int SPEED3 = 1,
    parameter int SPEED4 = 3, parameter int SPEED5 = 2, parameter int SPEED6 = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [2:0] level,
    input  logic       pause,
    output logic [9:0] car_x1,
    output logic [9:0] car_x2,
    output logic [9:0] car_x3,
    output logic [9:0] car_x4,
    output logic [9:0] car_x5,
    output logic [9:0] car_x6,
    output logic       collision,
    output logic [2:0] hit_lane,
    output logic       busy
);
    localparam int NUM_LANES = 6;

    typedef enum logic [1:0] {IDLE, UPDATE, CHECK} state_t;

    function automatic int lane_speed(input int i);
        case (i)
            0: return SPEED1;
            1: return SPEED2;
            2: return SPEED3;
            3: return SPEED4;
            4: return SPEED5;
            default: return SPEED6;
        endcase
    endfunction

    function automatic int lane_y(input int i);
        case (i)
            0: return CAR_Y1;
            1: return CAR_Y2;
            2: return CAR_Y3;
            3: return CAR_Y4;
            4: return CAR_Y5;
            default: return CAR_Y6;
        endcase
    endfunction

    state_t                      state;
    logic [2:0]                  idx;
    logic                        hit_flag;
    logic [2:0]                  first_lane;
    logic [NUM_LANES-1:0][9:0]   car_x;
    logic [NUM_LANES-1:0][9:0]   x_next;
    logic [NUM_LANES-1:0]        overlap;
    logic                        frame_start;
    logic                        hit_now;
    logic                        last;

    // Odd-numbered lanes (index 0, 2, 4) drive left, the others right.
    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            car_lane #(
                .H_DISPLAY(H_DISPLAY), .CAR_WIDTH(CAR_WIDTH), .CAR_HEIGHT(CAR_HEIGHT),
                .PLAYER_WIDTH(PLAYER_WIDTH), .PLAYER_HEIGHT(PLAYER_HEIGHT),
                .CAR_Y(lane_y(g)), .SPEED(lane_speed(g)), .MOVE_LEFT((g % 2) == 0)
            ) u_lane (
                .x(car_x[g]), .level(level), .player_x(player_x), .player_y(player_y),
                .x_next(x_next[g]), .overlap(overlap[g])
            );
        end
    endgenerate

    assign frame_start = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY)) && !pause;
    assign hit_now     = |(overlap & ({{(NUM_LANES-1){1'b0}}, 1'b1} << idx));
    assign last        = (idx == 3'(NUM_LANES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= 3'd0;
            car_x      <= {10'd500, 10'd400, 10'd300, 10'd200, 10'd100, 10'd0};
            collision  <= 1'b0;
            hit_lane   <= 3'd0;
            busy       <= 1'b0;
            hit_flag   <= 1'b0;
            first_lane <= 3'd0;
        end else begin
            collision <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= UPDATE;
                        idx   <= 3'd0;
                        busy  <= 1'b1;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < NUM_LANES; i++)
                        if (idx == 3'(i)) car_x[i] <= x_next[i];
                    if (last) begin
                        state      <= CHECK;
                        idx        <= 3'd0;
                        hit_flag   <= 1'b0;
                        first_lane <= 3'd0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                CHECK: begin
                    if (hit_now && !hit_flag) first_lane <= idx + 3'd1;
                    hit_flag <= hit_flag | hit_now;
                    if (last) begin
                        // The last lane's result is folded in directly since the flag lags a cycle.
                        collision <= hit_flag | hit_now;
                        hit_lane  <= hit_flag ? first_lane : (hit_now ? idx + 3'd1 : 3'd0);
                        state     <= IDLE;
                        idx       <= 3'd0;
                        busy      <= 1'b0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign car_x1 = car_x[0];
    assign car_x2 = car_x[1];
    assign car_x3 = car_x[2];
    assign car_x4 = car_x[3];
    assign car_x5 = car_x[4];
    assign car_x6 = car_x[5];
endmodule
